// File: rtl/lfsr_gen_if.sv
// Control/status bundle for lfsr_gen: step/burst/load controls in, LFSR state and flags out.
interface lfsr_gen_if #(
  parameter int WIDTH = 8
);
  logic             mode;
  logic             enable;
  logic             load;
  logic [WIDTH-1:0] seed;
  logic             taps_we;
  logic [WIDTH-1:0] taps_in;
  logic             start;
  logic [15:0]      count;
  logic [WIDTH-1:0] lfsr_out;
  logic             bit_out;
  logic             busy;
  logic             done;
  logic             lockup;
  logic             period_wrap;

  modport master (
    output mode, enable, load, seed, taps_we, taps_in, start, count,
    input  lfsr_out, bit_out, busy, done, lockup, period_wrap
  );

  modport slave (
    input  mode, enable, load, seed, taps_we, taps_in, start, count,
    output lfsr_out, bit_out, busy, done, lockup, period_wrap
  );
endinterface

// File: rtl/lfsr_gen.sv
// Galois/Fibonacci LFSR with programmable taps, seed load with zero-seed rejection,
// free-run stepping and counted bursts with done/period-wrap pulses.
module lfsr_gen #(
  parameter int               WIDTH        = 8,
  parameter logic [WIDTH-1:0] DEFAULT_TAPS = WIDTH'(8'hB8),
  parameter logic [WIDTH-1:0] DEFAULT_SEED = WIDTH'(1)
) (
  input logic       clock,
  input logic       reset_n,
  lfsr_gen_if.slave bus
);
  typedef enum logic {IDLE, BURST} fsm_t;

  fsm_t             fsm;
  logic [WIDTH-1:0] state;
  logic [WIDTH-1:0] ref_seed;
  logic [WIDTH-1:0] taps;
  logic [WIDTH-1:0] next_state;
  logic [WIDTH-1:0] galois_next;
  logic [WIDTH-1:0] fib_next;
  logic [WIDTH-1:0] fib_taps;
  logic [15:0]      remaining;
  logic             busy;
  logic             done;
  logic             lockup;
  logic             period_wrap;
  logic             galois_fb;
  logic             fib_fb;
  logic             step;

  // The top tap is always implied in Fibonacci mode, so a non-zero state never maps to zero.
  always_comb begin
    galois_fb   = state[WIDTH-1];
    galois_next = {state[WIDTH-2:0], galois_fb} ^
                  ({taps[WIDTH-1:1], 1'b0} & {WIDTH{galois_fb}});
    fib_taps    = taps | {1'b1, {(WIDTH-1){1'b0}}};
    fib_fb      = ^(fib_taps & state);
    fib_next    = {state[WIDTH-2:0], fib_fb};
    next_state  = bus.mode ? fib_next : galois_next;
  end

  assign busy = (fsm == BURST);
  assign step = busy || bus.enable;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fsm         <= IDLE;
      state       <= DEFAULT_SEED;
      ref_seed    <= DEFAULT_SEED;
      taps        <= DEFAULT_TAPS;
      remaining   <= 16'd0;
      done        <= 1'b0;
      lockup      <= 1'b0;
      period_wrap <= 1'b0;
    end else begin
      done        <= 1'b0;
      period_wrap <= 1'b0;
      if (bus.taps_we && !busy) begin
        taps <= bus.taps_in;
      end
      // Load wins over everything and silently aborts a running burst.
      if (bus.load) begin
        fsm       <= IDLE;
        remaining <= 16'd0;
        if (bus.seed != '0) begin
          state    <= bus.seed;
          ref_seed <= bus.seed;
          lockup   <= 1'b0;
        end else begin
          state    <= DEFAULT_SEED;
          ref_seed <= DEFAULT_SEED;
          lockup   <= 1'b1;
        end
      end else if (bus.start && !busy) begin
        if (bus.count == 16'd0) begin
          done <= 1'b1;
        end else begin
          fsm       <= BURST;
          remaining <= bus.count;
        end
      end else if (step) begin
        state <= next_state;
        if (next_state == ref_seed) begin
          period_wrap <= 1'b1;
        end
        if (busy) begin
          remaining <= remaining - 16'd1;
          if (remaining == 16'd1) begin
            fsm  <= IDLE;
            done <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.lfsr_out    = state;
  assign bus.bit_out     = state[WIDTH-1];
  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.lockup      = lockup;
  assign bus.period_wrap = period_wrap;
endmodule

// File: doc/lfsr_gen.md
LFSR_GEN -- requirements
Module: lfsr_gen

Interface
REQ-001 Parameter WIDTH, default 8: LFSR length in bits; legal range 3..32.
REQ-002 Parameter DEFAULT_TAPS, default 8'hB8: tap mask loaded at reset.
REQ-003 Parameter DEFAULT_SEED, default 1: state loaded at reset; SHALL be non-zero.
REQ-004 clock  input  1  sole clock; all state updates on the rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 mode  input  1  0 = Galois, 1 = Fibonacci; sampled on every step.
REQ-007 enable  input  1  free-run step request, honoured only when idle.
REQ-008 load  input  1  loads seed into the state.
REQ-009 seed  input  WIDTH  value for load.
REQ-010 taps_we  input  1  writes taps_in to the tap register.
REQ-011 taps_in  input  WIDTH  tap mask; bit i = polynomial term x^i.
REQ-012 start  input  1  starts a burst of count steps.
REQ-013 count  input  16  burst length, sampled with start.
REQ-014 lfsr_out  output  WIDTH  current state register.
REQ-015 bit_out  output  1  lfsr_out[WIDTH-1], combinational from state.
REQ-016 busy  output  1  burst in progress.
REQ-017 done  output  1  one-cycle pulse at burst completion.
REQ-018 lockup  output  1  sticky: an all-zero seed was rejected.
REQ-019 period_wrap  output  1  one-cycle pulse when a step returns the state to the reference seed.

Function
REQ-020 Galois step SHALL set fb = s[W-1], next[0] = fb, and next[i] = s[i-1] ^ (taps[i] & fb) for i = 1..W-1.
REQ-021 Fibonacci step SHALL set fb = XOR over i of (taps[i] & s[i]), with taps[W-1] treated as 1, and next = {s[W-2:0], fb}.
REQ-022 A step occurs when busy = 1, or when busy = 0 and enable = 1; otherwise the state SHALL hold.
REQ-023 Per-cycle priority SHALL be: load, then start acceptance, then step.
REQ-024 Load with a non-zero seed SHALL set state = seed and reference seed = seed, and SHALL clear lockup.
REQ-025 Load with seed = 0 SHALL set state = DEFAULT_SEED and reference seed = DEFAULT_SEED, and SHALL set lockup.
REQ-026 Load while busy SHALL abort the burst: busy drops next cycle and done does not pulse.
REQ-027 start with busy = 0, no load, and count = N > 0 SHALL raise busy on the next edge; the state then advances exactly N times on N consecutive cycles.
REQ-028 busy SHALL fall on the edge that performs the Nth step; done SHALL pulse on the following cycle.
REQ-029 start with count = 0 SHALL perform no step and SHALL pulse done on the next cycle; busy stays 0.
REQ-030 start while busy SHALL be ignored.
REQ-031 enable SHALL be ignored while busy.
REQ-032 taps_we SHALL update the taps on the next edge when busy = 0 and SHALL be ignored while busy.
REQ-033 A mode change SHALL take effect on the next step; the state is not modified.
REQ-034 period_wrap SHALL pulse for one cycle after any step whose next state equals the reference seed; a load SHALL NOT pulse it.
REQ-035 The all-zero state SHALL be unreachable in both modes (non-zero state always steps to non-zero).

Reset
REQ-036 While reset_n = 0, the block SHALL hold: state = DEFAULT_SEED, reference seed = DEFAULT_SEED, taps = DEFAULT_TAPS, and busy, done, lockup, period_wrap = 0.
REQ-037 Reset mid-burst SHALL abandon the burst without a done pulse.
REQ-038 After reset_n rises, the first step SHALL occur no earlier than the first rising edge.

Verification
REQ-039 WIDTH=4, taps=4'b0011, mode=0, load 4'h1, enable high -> sequence 2,4,8,3,6,C,B,5,A,7,E,F,D,9,1; period_wrap pulses after step 15.
REQ-040 WIDTH=4, taps=4'b1100, mode=1, load 4'h1, enable high -> sequence 2,4,9,3,6,D,...; state returns to 1 after exactly 15 steps with a period_wrap pulse.
REQ-041 Load seed 0 -> lfsr_out = DEFAULT_SEED and lockup = 1; then load 4'h5 -> lockup = 0.
REQ-042 start with count = 5 -> busy high for 5 cycles, state advanced exactly 5 times, one done pulse; start with count = 0 -> done pulse, state unchanged.
REQ-043 Load asserted on the third cycle of a 10-step burst -> state = seed, busy drops, no done pulse.
REQ-044 reset_n driven low mid-burst -> all outputs at reset values immediately and no done pulse after release; taps_we while busy -> tap mask unchanged.
